hcf_controller: RTL
===================

// Module: hcf_controller
// PURPOSE
//   FSM controller that sequences the 16-bit subtractive HCF datapath (registers A/B, subtractor, comparator).
//   - Loads operand A, then operand B, from data_in.
//   - Each cycle, subtracts the smaller register from the larger until the comparator reports equal.
//   - Signals completion with a start/busy/done handshake; the result is then held in register A.
//   - Guards against non-terminating inputs (e.g. one operand zero) with an iteration limit.
// PARAMETERS
//   CNT_W     16     width of the subtract-iteration counter and of the iters output
//   MAX_ITER  65535  subtract cycles allowed before aborting with err (must be < 2**CNT_W)
// PORTS
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled in IDLE only; operand A must be on data_in in this cycle
//   abort   in   1      synchronous cancel of a running operation
//   lt      in   1      datapath comparator: A < B
//   gt      in   1      datapath comparator: A > B
//   eq      in   1      datapath comparator: A == B
//   ldA     out  1      load enable, register A
//   ldB     out  1      load enable, register B
//   sel1    out  1      subtractor minuend mux: 0 = A, 1 = B
//   sel2    out  1      subtractor subtrahend mux: 0 = A, 1 = B
//   sel_in  out  1      bus mux: 0 = subtractor output, 1 = data_in
//   ready   out  1      high in IDLE; requester must present operand B on data_in in the cycle after start
//   busy    out  1      high in LOAD_B and RUN
//   done    out  1      one-cycle pulse at the end of every operation, including an error end
//   err     out  1      one-cycle pulse together with done when MAX_ITER is exceeded
//   iters   out  CNT_W  subtract count of the current or last operation; holds until the next start
// BEHAVIOUR
//   Reset (rst_n low): state = IDLE; iters = 0.
//   - While rst_n is low, ldA = ldB = 0; sel_in = 1, sel1 = 0, sel2 = 0; done = err = busy = 0.
//   Control outputs are decoded combinationally (Mealy) from state, start, abort, lt, gt and eq.
//   States:
//   - IDLE: ready = 1, sel_in = 1.
//     - start & !abort: ldA = 1, iters <= 0, go to LOAD_B.
//     - Otherwise stay; abort is ignored in IDLE.
//   - LOAD_B: sel_in = 1.
//     - abort: go to IDLE, ldB = 0.
//     - Otherwise: ldB = 1, go to RUN.
//   - RUN: sel_in = 0. Priority: abort > eq > iteration limit > subtract.
//     - abort: go to IDLE, no load.
//     - eq: go to DONE, no load.
//     - iters == MAX_ITER: go to ERR, no load.
//     - gt: sel1 = 0, sel2 = 1, ldA = 1 (A <= A - B), iters++.
//     - lt: sel1 = 1, sel2 = 0, ldB = 1 (B <= B - A), iters++.
//   - DONE: done = 1, go to IDLE; start is ignored in this cycle.
//   - ERR: done = err = 1, go to IDLE; start is ignored in this cycle.
//   Latency: start accepted in cycle 0 -> done high in cycle N+3, where N = subtract count.
//   Comparator flags are read only in RUN, where both registers hold settled values.
//   Illegal flag combinations (none set, or more than one set) in RUN are treated as eq.
//   Zero operands:
//   - A = B = 0: eq immediately; result 0.
//   - Exactly one operand 0: the loop never converges; terminates through the err path.
//   Abort mid-operation: no done pulse; register contents are don't-care; iters holds its value.
//   Async reset mid-operation: immediate return to IDLE; outputs take reset values.
//   iters never wraps: the MAX_ITER check fires before any increment past MAX_ITER.
// STRUCTURE
//   Shared package hcf_pkg.vh holds:
//   - State encodings: IDLE, LOAD_B, RUN, DONE, ERR.
//   - Mux select constants: SEL_A = 0, SEL_B = 1, BUS_SUB = 0, BUS_IN = 1.
//   One sub-module, hcf_iter_counter (CNT_W): clear / increment / limit-hit compare.
//   Next-state logic and output decode stay in hcf_controller.
// TESTING (top-level bench: this controller + datapath)
//   1. A = 48, B = 18 -> subtract sequence A = 30, A = 12, B = 6, A = 6; done in cycle 7; A = 6; iters = 4; err = 0.
//   2. A = 21, B = 21 -> no loads in RUN; done in cycle 3; A = 21; iters = 0.
//      A = 0, B = 0 -> done in cycle 3; A = 0.
//   3. MAX_ITER = 8; A = 0, B = 5 -> exactly 8 ldB pulses; done & err in cycle 11; then IDLE; ready = 1.
//   4. A = 65535, B = 1 (default MAX_ITER) -> 65534 subtracts; A = 1; err = 0; no counter wrap.
//   5. A = 100, B = 75; abort in cycle 4 -> no load in that cycle; IDLE in cycle 5; done never asserted.
//      A following start with A = 9, B = 6 -> A = 3.
//   6. start held high through a whole operation -> only the IDLE-cycle start is accepted; start in the DONE cycle is ignored.
//      rst_n low mid-RUN -> ldA = ldB = 0 immediately; IDLE after release.

Source files
------------

// File: rtl/hcf_pkg.sv
// Shared definitions for the subtractive HCF controller: state encoding and datapath mux selects.
package hcf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    RUN    = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;
  localparam logic BUS_SUB = 1'b0;
  localparam logic BUS_IN  = 1'b1;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned MAX_ITER_DEF = 65535;

endpackage

// File: rtl/hcf_iter_counter.sv
// Subtract-iteration counter: clears on operation start, increments per subtract, flags the limit.
module hcf_iter_counter
  import hcf_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_limit_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  // Checked before any increment, so count never passes MAX_ITER.
  assign at_limit_c = (count == CNT_W'(MAX_ITER));

endmodule

// File: rtl/hcf_controller.sv
// Sequencing FSM for the subtractive HCF datapath; control outputs are Mealy-decoded from state and flags.
module hcf_controller
  import hcf_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iters
);

  state_t state, state_nxt;
  logic   cnt_clr, cnt_inc, at_limit_c;
  logic   sub_gt, sub_lt;

  hcf_iter_counter #(
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .count      (iters),
    .at_limit_c (at_limit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Only a cleanly one-hot gt/lt subtracts; anything else (eq or illegal) ends the loop.
  assign sub_gt = gt & ~lt & ~eq;
  assign sub_lt = lt & ~gt & ~eq;

  always_comb begin
    state_nxt = state;
    ldA       = 1'b0;
    ldB       = 1'b0;
    sel1      = SEL_A;
    sel2      = SEL_A;
    sel_in    = BUS_IN;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        // rst_n gate keeps ldA low while reset is asserted, even with start high.
        if (start && !abort && rst_n) begin
          ldA       = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          ldB       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        sel_in = BUS_SUB;
        if (abort) begin
          state_nxt = IDLE;
        end else if (!sub_gt && !sub_lt) begin
          state_nxt = DONE;
        end else if (at_limit_c) begin
          state_nxt = ERR;
        end else if (sub_gt) begin
          sel2    = SEL_B;
          ldA     = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          sel1    = SEL_B;
          ldB     = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
